// File: rtl/game_pkg.sv
// Shared types, widths and the score clamp helper for the game counter controller.
package game_pkg;

  localparam int TICK_CYCLES_DEF = 500000;
  localparam int MAX_SCORE_DEF   = 114000;
  localparam int SCORE_W         = 17;
  localparam int CHANGE_W        = 13;
  localparam int TIME_W          = 11;

  // Game FSM encoding is visible on the game_state output, so values are fixed.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } game_state_t;

  // Arbiter phase: grants only in ARB, SETTLE gives the score counter one cycle to update.
  typedef enum logic {
    PH_ARB    = 1'b0,
    PH_SETTLE = 1'b1
  } arb_phase_t;

  // Limit a score change so the score stays within 0..max_score.
  // Computed in SCORE_W bits; the result never exceeds amt, so it fits CHANGE_W bits.
  function automatic logic [CHANGE_W-1:0] clamp_change(
    input logic                sub,
    input logic [CHANGE_W-1:0] amt,
    input logic [SCORE_W-1:0]  score,
    input logic [SCORE_W-1:0]  max_score
  );
    logic [SCORE_W-1:0] amt_w;
    logic [SCORE_W-1:0] lim;
    amt_w = {{(SCORE_W-CHANGE_W){1'b0}}, amt};
    if (sub) begin
      lim = score;
    end else if (score >= max_score) begin
      lim = '0;
    end else begin
      lim = max_score - score;
    end
    if (amt_w < lim) begin
      return amt;
    end
    return lim[CHANGE_W-1:0];
  endfunction

endpackage

// File: rtl/game_counter_ctrl_score_arbiter.sv
// Round-robin arbiter that funnels score requests onto the single add/sub port.
//
// Handshake: each requester holds req[i] (with req_sub[i]/amount stable) until it
// sees req_ack[i] high for one cycle; it must drop req[i] on the following edge.
// An ack is only ever issued in the ARB phase, so a requester that drops its
// request at the ack edge is never acknowledged twice.
module score_arbiter
  import game_pkg::*;
#(
  parameter int N_REQ     = 3,
  parameter int MAX_SCORE = MAX_SCORE_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en_i,
  input  logic                      clr_i,
  input  logic                      play_i,
  input  logic [N_REQ-1:0]          req_i,
  input  logic [N_REQ-1:0]          req_sub_i,
  input  logic [N_REQ*CHANGE_W-1:0] req_amt_i,
  input  logic [SCORE_W-1:0]        score_count_i,
  output logic [N_REQ-1:0]          req_ack_o,
  output logic [CHANGE_W-1:0]       score_change_o,
  output logic                      add_sub_o
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [SCORE_W-1:0] MAX_S = SCORE_W'(MAX_SCORE);

  arb_phase_t         phase_q, phase_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;

  logic               found;
  logic               grant;
  int                 idx;
  int                 gnt_idx;
  int                 nxt_idx;
  logic [CHANGE_W-1:0] amt_sel;

  // Pointer and phase registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= PH_ARB;
      ptr_q   <= '0;
    end else begin
      phase_q <= phase_d;
      ptr_q   <= ptr_d;
    end
  end

  // Round-robin search from the pointer, grant/discard decision and clamp.
  always_comb begin
    found          = 1'b0;
    idx            = 0;
    gnt_idx        = 0;
    nxt_idx        = 0;
    req_ack_o      = '0;
    score_change_o = '0;
    add_sub_o      = 1'b0;
    ptr_d          = ptr_q;
    phase_d        = phase_q;

    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
      if (!found && req_i[idx]) begin
        found   = 1'b1;
        gnt_idx = idx;
      end
    end

    amt_sel = req_amt_i[gnt_idx*CHANGE_W +: CHANGE_W];
    grant   = found && (phase_q == PH_ARB) && !clr_i && en_i;

    if (grant) begin
      req_ack_o[gnt_idx] = 1'b1;
      // Outside PLAY the request is acknowledged but its amount is discarded.
      if (play_i) begin
        add_sub_o      = req_sub_i[gnt_idx];
        score_change_o = clamp_change(req_sub_i[gnt_idx], amt_sel, score_count_i, MAX_S);
      end
      nxt_idx = gnt_idx + 1;
      if (nxt_idx >= N_REQ) begin
        nxt_idx = 0;
      end
      ptr_d   = PTR_W'(nxt_idx);
      phase_d = PH_SETTLE;
    end else if (phase_q == PH_SETTLE) begin
      phase_d = PH_ARB;
    end

    // A new game restarts arbitration from requester 0.
    if (clr_i) begin
      ptr_d   = '0;
      phase_d = PH_ARB;
    end
  end

endmodule

// File: rtl/game_counter_ctrl.sv
// Game sequencing controller: game-state FSM, one-second tick and score arbitration.
module game_counter_ctrl
  import game_pkg::*;
#(
  parameter int TICK_CYCLES = TICK_CYCLES_DEF,
  parameter int MAX_SCORE   = MAX_SCORE_DEF,
  parameter int N_REQ       = 3
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic                      start,
  input  logic                      pause,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          req_sub,
  input  logic [N_REQ*CHANGE_W-1:0] req_amt,
  output logic [N_REQ-1:0]          req_ack,
  input  logic [SCORE_W-1:0]        score_count,
  output logic [CHANGE_W-1:0]       score_change,
  output logic                      add_sub,
  input  logic [TIME_W-1:0]         time_left,
  input  logic                      level_end,
  input  logic                      treasure_end,
  output logic                      timer_run,
  output logic                      tick_1hz,
  output logic                      counters_clr,
  output logic [1:0]                game_state,
  output logic                      game_over
);

  localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);

  game_state_t       state_q, state_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              run_q;
  logic              start_ok;
  logic              tick_wrap;
  logic              in_play;

  // run_q is low while reset is held, forcing every input-driven output to 0.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  // Game state and tick counter registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
    end
  end

  // Next-state logic for the game FSM and tick counter.
  always_comb begin
    state_d    = state_q;
    start_ok   = 1'b0;
    in_play    = (state_q == ST_PLAY);
    tick_wrap  = in_play && (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick_cnt_q;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        // start wins over a simultaneous pause here since pause is not looked at.
        if (start && run_q) begin
          state_d  = ST_PLAY;
          start_ok = 1'b1;
        end
      end
      ST_PLAY: begin
        // A terminal condition beats pause in the same cycle.
        if ((time_left == '0) || level_end || treasure_end) begin
          state_d = ST_OVER;
        end else if (pause) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (pause) begin
          state_d = ST_PLAY;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (start_ok) begin
      tick_cnt_d = '0;
    end else if (in_play) begin
      tick_cnt_d = tick_wrap ? '0 : tick_cnt_q + TICK_W'(1);
    end
  end

  // Status outputs derived from registered state.
  always_comb begin
    timer_run    = (state_q == ST_PLAY);
    game_state   = state_q;
    game_over    = (state_q == ST_OVER);
    tick_1hz     = tick_wrap && run_q;
    counters_clr = start_ok;
  end

  score_arbiter #(
    .N_REQ     (N_REQ),
    .MAX_SCORE (MAX_SCORE)
  ) u_score_arbiter (
    .clk            (Clk),
    .rst_n          (Reset_n),
    .en_i           (run_q),
    .clr_i          (start_ok),
    .play_i         (state_q == ST_PLAY),
    .req_i          (req),
    .req_sub_i      (req_sub),
    .req_amt_i      (req_amt),
    .score_count_i  (score_count),
    .req_ack_o      (req_ack),
    .score_change_o (score_change),
    .add_sub_o      (add_sub)
  );

endmodule

// File: tb/tb_game_counter_ctrl.sv
// Directed bench for game_counter_ctrl with a short tick period.
module tb_game_counter_ctrl;

  logic        Clk;
  logic        Reset_n;
  logic        start;
  logic        pause;
  logic [2:0]  req;
  logic [2:0]  req_sub;
  logic [38:0] req_amt;
  logic [2:0]  req_ack;
  logic [16:0] score_count;
  logic [12:0] score_change;
  logic        add_sub;
  logic [10:0] time_left;
  logic        level_end;
  logic        treasure_end;
  logic        timer_run;
  logic        tick_1hz;
  logic        counters_clr;
  logic [1:0]  game_state;
  logic        game_over;

  int checks = 0;
  int errors = 0;

  game_counter_ctrl #(
    .TICK_CYCLES (10),
    .MAX_SCORE   (114000),
    .N_REQ       (3)
  ) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .start        (start),
    .pause        (pause),
    .req          (req),
    .req_sub      (req_sub),
    .req_amt      (req_amt),
    .req_ack      (req_ack),
    .score_count  (score_count),
    .score_change (score_change),
    .add_sub      (add_sub),
    .time_left    (time_left),
    .level_end    (level_end),
    .treasure_end (treasure_end),
    .timer_run    (timer_run),
    .tick_1hz     (tick_1hz),
    .counters_clr (counters_clr),
    .game_state   (game_state),
    .game_over    (game_over)
  );

  // Clock and reset block.
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    Reset_n = 1'b0; start = 1'b1; pause = 1'b0; req = 3'b010; req_sub = '0;
    req_amt = {13'd0, 13'd300, 13'd0}; score_count = '0; time_left = 11'd100;
    level_end = 1'b0; treasure_end = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_state", game_state, 0);
    chk("rst_ack", req_ack, 0);
    chk("rst_clr", counters_clr, 0);
    chk("rst_run", timer_run, 0);
    chk("rst_tick", tick_1hz, 0);
    chk("rst_change", score_change, 0);
    chk("rst_over", game_over, 0);

    next_cycle(); Reset_n = 1'b1; start = 1'b0; req = '0;

    // Start a game; tick period 10 with a 7-cycle pause beginning at cycle 15.
    next_cycle(); start = 1'b1; #1;
    chk("start_clr", counters_clr, 1);
    chk("start_state", game_state, 0);
    for (int c = 1; c <= 28; c++) begin
      next_cycle(); start = 1'b0;
      pause = (c == 15 || c == 22);
      #1;
      chk($sformatf("tick_c%0d", c), tick_1hz, (c == 10 || c == 27));
      if (c == 1) begin
        chk("play_state", game_state, 1);
        chk("play_run", timer_run, 1);
        chk("play_clr_gone", counters_clr, 0);
      end
      if (c == 16) chk("paused_state", game_state, 2);
      if (c == 16) chk("paused_run", timer_run, 0);
      if (c == 23) chk("resumed_state", game_state, 1);
    end
    pause = 1'b0;

    // Three simultaneous requests: round-robin 0,1,2 on alternating cycles.
    next_cycle(); score_count = 17'd2000; req_sub = 3'b110;
    req_amt = {13'd100, 13'd100, 13'd4000}; req = 3'b111; #1;
    chk("rr_ack0", req_ack, 3'b001);
    chk("rr_chg0", score_change, 4000);
    chk("rr_sub0", add_sub, 0);
    next_cycle(); req = 3'b110; score_count = 17'd6000; #1;
    chk("rr_settle0", req_ack, 0);
    chk("rr_settle0_chg", score_change, 0);
    next_cycle(); #1;
    chk("rr_ack1", req_ack, 3'b010);
    chk("rr_chg1", score_change, 100);
    chk("rr_sub1", add_sub, 1);
    next_cycle(); req = 3'b100; score_count = 17'd5900; #1;
    chk("rr_settle1", req_ack, 0);
    next_cycle(); #1;
    chk("rr_ack2", req_ack, 3'b100);
    chk("rr_chg2", score_change, 100);
    next_cycle(); req = '0; score_count = 17'd5800; #1;
    chk("rr_idle_ack", req_ack, 0);

    // Clamp at zero on subtract and at the ceiling on add.
    next_cycle(); score_count = 17'd50; req_sub = 3'b100;
    req_amt = {13'd100, 13'd0, 13'd0}; req = 3'b100; #1;
    chk("clamp_lo_ack", req_ack, 3'b100);
    chk("clamp_lo_chg", score_change, 50);
    chk("clamp_lo_sub", add_sub, 1);
    next_cycle(); req = '0; score_count = 17'd0; #1;
    next_cycle(); score_count = 17'd113000; req_sub = 3'b000;
    req_amt = {13'd0, 13'd0, 13'd5000}; req = 3'b001; #1;
    chk("clamp_hi_ack", req_ack, 3'b001);
    chk("clamp_hi_chg", score_change, 1000);
    chk("clamp_hi_sub", add_sub, 0);
    next_cycle(); req = '0; score_count = 17'd114000; #1;
    chk("clamp_hi_settle", score_change, 0);

    // Pointer sits at 1 after granting 0: requesters 0 and 2 -> 2 first.
    next_cycle(); score_count = 17'd1000; req_sub = 3'b101;
    req_amt = {13'd20, 13'd0, 13'd10}; req = 3'b101; #1;
    chk("ptr_ack2", req_ack, 3'b100);
    chk("ptr_chg2", score_change, 20);
    next_cycle(); req = 3'b001; score_count = 17'd980; #1;
    chk("ptr_settle", req_ack, 0);
    next_cycle(); #1;
    chk("ptr_ack0", req_ack, 3'b001);
    chk("ptr_chg0", score_change, 10);
    next_cycle(); req = '0; score_count = 17'd970; #1;

    // Timer expiry ends the game; requests in OVER are acked and discarded.
    next_cycle(); time_left = 11'd0; #1;
    chk("expire_same_cycle", game_state, 1);
    next_cycle(); time_left = 11'd100; req = 3'b001; req_sub = 3'b000;
    req_amt = {13'd0, 13'd0, 13'd500}; #1;
    chk("over_state", game_state, 3);
    chk("over_flag", game_over, 1);
    chk("over_run", timer_run, 0);
    chk("over_ack", req_ack, 3'b001);
    chk("over_chg", score_change, 0);
    chk("over_sub", add_sub, 0);
    next_cycle(); req = '0; #1;
    chk("over_hold", game_state, 3);

    // Restart: no grant in the clear cycle, then the held request is served.
    next_cycle(); start = 1'b1; req = 3'b010; req_amt = {13'd0, 13'd100, 13'd0};
    score_count = 17'd1000; #1;
    chk("restart_clr", counters_clr, 1);
    chk("restart_no_ack", req_ack, 0);
    next_cycle(); start = 1'b0; #1;
    chk("restart_state", game_state, 1);
    chk("restart_clr_gone", counters_clr, 0);
    chk("restart_ack", req_ack, 3'b010);
    chk("restart_chg", score_change, 100);
    next_cycle(); req = '0; start = 1'b1; #1;
    chk("start_in_play", counters_clr, 0);
    next_cycle(); start = 1'b0; #1;
    chk("start_in_play_state", game_state, 1);

    // Terminal flag beats pause.
    next_cycle(); treasure_end = 1'b1; pause = 1'b1; #1;
    next_cycle(); treasure_end = 1'b0; pause = 1'b0; #1;
    chk("term_vs_pause", game_state, 3);

    // Reset asserted mid-PLAY with a pending request.
    next_cycle(); start = 1'b1; #1;
    chk("clr_again", counters_clr, 1);
    next_cycle(); start = 1'b0; #1;
    chk("play_again", game_state, 1);
    next_cycle(); req = 3'b010; Reset_n = 1'b0; #1;
    chk("midrst_state", game_state, 0);
    chk("midrst_ack", req_ack, 0);
    chk("midrst_run", timer_run, 0);
    chk("midrst_chg", score_change, 0);
    next_cycle(); #1;
    chk("midrst_ack_held", req_ack, 0);
    next_cycle(); Reset_n = 1'b1; req = '0;

    // start and pause together in IDLE: start wins.
    next_cycle(); start = 1'b1; pause = 1'b1; #1;
    chk("idle_start_pause_clr", counters_clr, 1);
    next_cycle(); start = 1'b0; pause = 1'b0; #1;
    chk("idle_start_pause_state", game_state, 1);

    // level_end also ends the game.
    next_cycle(); level_end = 1'b1; #1;
    next_cycle(); level_end = 1'b0; #1;
    chk("level_end_over", game_state, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_counter_ctrl.md
Name: game_counter_ctrl

Overview:
- Sequencing controller for the game counter datapath: score accumulator, one-second timer, level counter and treasure counter.
- Runs the game-state FSM (IDLE/PLAY/PAUSE/OVER) and generates the one-second tick and timer run enable.
- Arbitrates three score-change requesters (treasure pickup, log hit, pit fall) onto the single score add/sub port, clamping results to 0..MAX_SCORE.

Parameters:
- TICK_CYCLES, 500000: Clk cycles per one-second tick.
- MAX_SCORE, 114000: score ceiling.
- N_REQ, 3: number of score requesters (fixed at 3 for this revision).

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous, active-low reset.
- start  in  1  pulse: begin a new game (IDLE or OVER -> PLAY).
- pause  in  1  pulse: toggle PLAY <-> PAUSE.
- req  in  3  score requests, level-held until ack; bit 0 = treasure, bit 1 = log, bit 2 = pit.
- req_sub  in  3  per requester: 1 = subtract, 0 = add.
- req_amt  in  39  per requester 13-bit amount; requester i uses bits [13i+12:13i].
- req_ack  out  3  one-hot, one-cycle acknowledge.
- score_count  in  17  current score from the score counter.
- score_change  out  13  amount sent to the score counter.
- add_sub  out  1  1 = subtract, 0 = add.
- time_left  in  11  timer value.
- level_end  in  1  level counter terminal flag.
- treasure_end  in  1  treasure counter terminal flag.
- timer_run  out  1  timer enable.
- tick_1hz  out  1  one-cycle pulse per elapsed second.
- counters_clr  out  1  one-cycle synchronous clear to all counters.
- game_state  out  2  current FSM state (encoding below).
- game_over  out  1  high while state is OVER.

Behaviour:
- Reset (async, Reset_n = 0), all outputs 0:
  - game_state = IDLE; tick counter = 0; arbiter pointer = 0; arbiter phase = ARB.
  - score_change, add_sub, req_ack, timer_run, tick_1hz, counters_clr = 0.
  - Reset asserted mid-request drops that request with no ack.
- Game FSM, state encoding IDLE = 0, PLAY = 1, PAUSE = 2, OVER = 3:
  - IDLE/OVER + start -> PLAY. counters_clr = 1 for that cycle; tick counter and arbiter are cleared.
  - PLAY + pause -> PAUSE; PAUSE + pause -> PLAY. start is ignored in PLAY and PAUSE.
  - PLAY -> OVER when time_left == 0, level_end or treasure_end. This exit has priority over pause in the same cycle.
  - OVER is held until start.
- timer_run = (state == PLAY).
- Tick counter:
  - Counts only in PLAY and holds its value in PAUSE.
  - At TICK_CYCLES-1: tick_1hz = 1 for one cycle and the counter wraps to 0.
- Arbiter, round-robin:
  - Search starts at pointer (the requester after the last granted one).
  - Two phases: ARB then SETTLE. A grant is issued only in ARB; SETTLE is a single cycle that lets score_count reflect the change before the next clamp. Maximum throughput is 1 grant per 2 cycles.
  - Grant cycle (PLAY): req_ack[i] = 1, add_sub = req_sub[i], score_change = clamped amount. Outside grant cycles, score_change = 0 and add_sub = 0.
  - Clamp on subtract: change = min(amt, score_count).
  - Clamp on add: change = min(amt, MAX_SCORE - score_count).
  - Clamp width: the clamp is computed in 17 bits; the result always fits in 13 bits because it is ≤ amt.
  - In IDLE/PAUSE/OVER: requests are acked in round-robin order with score_change = 0 (discarded), keeping the same 2-cycle cadence. This stops stale events persisting across pause or restart.
  - In the counters_clr cycle no grant is issued.
- Simultaneous events:
  - start + pause in IDLE: start wins.
  - Terminal condition + tick in the same cycle: the tick is still emitted and the state becomes OVER on the next cycle.

Decomposition:
- Package game_pkg:
  - game_state_t enum.
  - TICK_CYCLES_DEF, MAX_SCORE_DEF.
  - SCORE_W = 17, CHANGE_W = 13, TIME_W = 11.
- Sub-module score_arbiter: round-robin pointer, ARB/SETTLE phase, clamp logic.
- FSM and tick counter stay in the top module.

Test Plan:
- Reset_n low mid-PLAY with req[1] pending -> next cycle game_state = 0, req_ack = 0, timer_run = 0, score_change = 0.
- TICK_CYCLES = 10, start then 25 cycles in PLAY -> tick_1hz pulses at cycles 10 and 20. Pause at cycle 15 for 7 cycles -> second pulse at cycle 27 instead.
- PLAY, req = 3'b111 (amounts 4000 add, 100 sub, 100 sub), score_count = 2000 -> acks one-hot in order 0, 1, 2 on alternating cycles; score_change = 4000, 100, 100.
- score_count = 50, pit subtract 100 -> score_change = 50, add_sub = 1. score_count = 113000, treasure add 5000 -> score_change = 1000.
- PLAY with time_left set to 0 -> game_state = 3, game_over = 1, timer_run = 0. Then req[0] -> acked with score_change = 0. Then start -> counters_clr pulse and game_state = 1.
- treasure_end and pause in the same cycle -> OVER, not PAUSE.
